// File: rtl/myuart_pkg.sv
// myuart_pkg: shared encodings and helpers for the myuart transmit path.
// Parity support is gated by MYUART_TX_PARITY_EN.
package myuart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } par_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'b00,
    STOP_1P5 = 2'b01,
    STOP_2   = 2'b10
  } stop_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [3:0] DATA_MIN = 4'd5;
  localparam logic [3:0] DATA_MAX = 4'd8;

  function automatic logic [3:0] clamp_bits(
    input logic [3:0] n
  );
    if (n < DATA_MIN) return DATA_MIN;
    if (n > DATA_MAX) return DATA_MAX;
    return n;
  endfunction

  function automatic logic [7:0] data_mask(
    input logic [3:0] n
  );
    logic [7:0] m;
    case (n)
      4'd5:    m = 8'h1f;
      4'd6:    m = 8'h3f;
      4'd7:    m = 8'h7f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/myuart_tx_if.sv
// myuart_tx_if: transmit request handshake between
// the register block (master) and the serializer (slave).
interface myuart_tx_if;
  logic       shoot_i;
  logic [7:0] datatx_i;
  logic       busytx_o;

  modport master (
    output shoot_i,
    output datatx_i,
    input  busytx_o
  );

  modport slave (
    input  shoot_i,
    input  datatx_i,
    output busytx_o
  );
endinterface

// File: rtl/myuart_baud_gen.sv
// myuart_baud_gen: one-cycle tick every div_i clocks.
// clear_i restarts the count so the first tick is a full period away.
module myuart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = (cnt_q == div_i - DIV_W'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clear_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/myuart_tx.sv
// myuart_tx: UART frame serializer (start, 5-8 data, parity, stop).
// Define MYUART_TX_PARITY_EN to build the parity bit and PARITY state.
module myuart_tx
  import myuart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int OVS_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  myuart_tx_if.slave       tx_if,
  input  logic [3:0]       data_bit_num_i,
  input  logic [1:0]       parity_type_i,
  input  logic [1:0]       stop_bit_num_i,
  input  logic [DIV_W-1:0] divisor_i,
  input  logic [OVS_W-1:0] oversample_rate_i,
  output logic             txd_o
);

  state_t           state_q, state_d;
  logic [7:0]       sh_q;
  logic [3:0]       n_q;
  logic [2:0]       bcnt_q;
  logic [1:0]       stop_q;
  logic [DIV_W-1:0] d_q;
  logic [OVS_W-1:0] r_q;
  logic [OVS_W:0]   ph_q, lim, r_ext;
  logic             txd_q, txd_d;
  logic             tick, accept, bit_end, last_bit;
  logic             par_on, pbit;
  logic [3:0]       n_acc;

  assign accept   = (state_q == ST_IDLE) && tx_if.shoot_i;
  assign n_acc    = clamp_bits(data_bit_num_i);
  assign last_bit = ({1'b0, bcnt_q} == n_q - 4'd1);
  assign r_ext    = {1'b0, r_q};
  assign bit_end  = tick && (ph_q == lim - (OVS_W+1)'(1));

  assign tx_if.busytx_o = (state_q != ST_IDLE);
  assign txd_o          = txd_q;

`ifdef MYUART_TX_PARITY_EN
  logic [1:0] par_q;
  logic       pbit_q, pbit_acc, ones_odd;

  assign ones_odd = ^(tx_if.datatx_i & data_mask(n_acc));
  assign pbit_acc = (parity_type_i == PAR_EVEN) ? ones_odd : ~ones_odd;
  assign par_on   = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  assign pbit     = pbit_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      par_q  <= PAR_NONE;
      pbit_q <= 1'b0;
    end else if (accept) begin
      par_q  <= parity_type_i;
      pbit_q <= pbit_acc;
    end
  end
`else
  logic unused_par;

  assign unused_par = ^parity_type_i;
  assign par_on     = 1'b0;
  assign pbit       = 1'b1;
`endif

  // stop length is counted in ticks, so 1.5 bits is R + R/2
  always_comb begin
    lim = r_ext;
    if (state_q == ST_STOP) begin
      case (stop_q)
        STOP_1:   lim = r_ext;
        STOP_1P5: lim = r_ext + (r_ext >> 1);
        default:  lim = r_ext << 1;
      endcase
    end
  end

  myuart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (accept),
    .div_i   (d_q),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txd_d   = 1'b1;
    unique case (state_q)
      ST_IDLE:
        if (accept) state_d = ST_START;
      ST_START:
        if (bit_end) state_d = ST_DATA;
      ST_DATA:
        if (bit_end && last_bit)
          state_d = par_on ? ST_PARITY : ST_STOP;
`ifdef MYUART_TX_PARITY_EN
      ST_PARITY:
        if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:
        if (bit_end) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
    // txd is registered, so decode it from the upcoming state
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = (state_q == ST_DATA && bit_end)
                         ? sh_q[1] : sh_q[0];
      ST_PARITY: txd_d = pbit;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      txd_q  <= 1'b1;
      sh_q   <= '0;
      n_q    <= '0;
      bcnt_q <= '0;
      stop_q <= '0;
      d_q    <= '0;
      r_q    <= '0;
      ph_q   <= '0;
    end else begin
      txd_q <= txd_d;
      if (accept) begin
        sh_q   <= tx_if.datatx_i;
        n_q    <= n_acc;
        stop_q <= stop_bit_num_i;
        d_q    <= (divisor_i == '0) ? DIV_W'(1) : divisor_i;
        r_q    <= (oversample_rate_i == '0) ? OVS_W'(1)
                                            : oversample_rate_i;
        bcnt_q <= '0;
        ph_q   <= '0;
      end else if (bit_end) begin
        ph_q <= '0;
        if (state_q == ST_DATA) begin
          sh_q   <= sh_q >> 1;
          bcnt_q <= bcnt_q + 3'd1;
        end
      end else if (tick) begin
        ph_q <= ph_q + (OVS_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_myuart_tx.sv
// tb_myuart_tx: directed frame checks for myuart_tx.
// Expected waveforms come from a per-cycle frame model in the bench.
module tb_myuart_tx;

`ifdef MYUART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  nbits;
  logic [1:0]  ptype;
  logic [1:0]  stype;
  logic [15:0] div;
  logic [7:0]  ovs;
  logic        txd;

  int  n_chk = 0;
  int  n_fail = 0;
  time t_start, t_end, prev_end;

  always #5 clk = ~clk;

  myuart_tx_if tx_if ();

  myuart_tx #(
    .DIV_W (16),
    .OVS_W (8)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .tx_if             (tx_if),
    .data_bit_num_i    (nbits),
    .parity_type_i     (ptype),
    .stop_bit_num_i    (stype),
    .divisor_i         (div),
    .oversample_rate_i (ovs),
    .txd_o             (txd)
  );

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cycles(input time a, input time b);
    return int'((b - a) / 10);
  endfunction

  task automatic send_check(
    input string      tag,
    input logic [7:0] b,
    input int         n,
    input logic [1:0] p,
    input logic [1:0] s,
    input int         d,
    input int         r,
    input int         inj
  );
    int   de, re, bt, ne, stc, cyc, bad, top;
    logic par;
    logic q[$];
    logic e[$];
    de = (d == 0) ? 1 : d;
    re = (r == 0) ? 1 : r;
    bt = de * re;
    ne = (n < 5) ? 5 : ((n > 8) ? 8 : n);
    stc = (s == 2'b00) ? bt :
          (s == 2'b01) ? de * (re + re / 2) : 2 * bt;
    repeat (bt) e.push_back(1'b0);
    par = 1'b0;
    for (int j = 0; j < ne; j++) begin
      par ^= b[j];
      repeat (bt) e.push_back(b[j]);
    end
    if (PEN && (p == 2'b01 || p == 2'b10)) begin
      repeat (bt) e.push_back((p == 2'b10) ? par : ~par);
    end
    repeat (stc) e.push_back(1'b1);

    @(negedge clk);
    nbits = n[3:0];
    ptype = p;
    stype = s;
    div   = d[15:0];
    ovs   = r[7:0];
    tx_if.datatx_i = b;
    tx_if.shoot_i  = 1'b1;
    @(posedge clk);
    #1;
    tx_if.shoot_i = 1'b0;
    t_start = $time;
    check_eq({tag, "_busy_on"}, tx_if.busytx_o, 1);
    check_eq({tag, "_start"}, txd, 0);

    cyc = 0;
    while (tx_if.busytx_o && cyc < 4000) begin
      if (cyc == inj) begin
        tx_if.shoot_i  = 1'b1;
        tx_if.datatx_i = 8'h55;
        div   = 16'd1;
        ovs   = 8'd1;
        nbits = 4'd5;
        ptype = ~p;
        stype = ~s;
      end else if (cyc == inj + 1) begin
        tx_if.shoot_i = 1'b0;
      end
      q.push_back(txd);
      @(posedge clk);
      #1;
      cyc++;
    end
    tx_if.shoot_i = 1'b0;
    t_end = $time;

    check_eq({tag, "_len"}, cyc, e.size());
    top = (q.size() > e.size()) ? q.size() : e.size();
    bad = 0;
    for (int i = 0; i < top; i++) begin
      if (i >= q.size() || i >= e.size()) bad++;
      else if (q[i] !== e[i]) bad++;
    end
    check_eq({tag, "_wave_errs"}, bad, 0);
    check_eq({tag, "_idle_txd"}, txd, 1);
  endtask

  initial begin
    tx_if.shoot_i  = 1'b0;
    tx_if.datatx_i = 8'h00;
    nbits = 4'd8;
    ptype = 2'b00;
    stype = 2'b00;
    div   = 16'd2;
    ovs   = 8'd4;

    #23;
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", tx_if.busytx_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_txd", txd, 1);
    check_eq("post_rst_busy", tx_if.busytx_o, 0);

    send_check("even", 8'h83, 8, 2'b10, 2'b00, 2, 4, -1);
    check_eq("even_88", cycles(t_start, t_end), PEN ? 88 : 80);
    send_check("odd", 8'h83, 8, 2'b01, 2'b00, 2, 4, -1);
    check_eq("odd_88", cycles(t_start, t_end), PEN ? 88 : 80);
    send_check("none", 8'h83, 8, 2'b00, 2'b00, 2, 4, -1);
    check_eq("none_80", cycles(t_start, t_end), 80);
    send_check("par11", 8'h83, 8, 2'b11, 2'b00, 2, 4, -1);
    check_eq("par11_80", cycles(t_start, t_end), 80);

    send_check("n5_even", 8'h83, 5, 2'b10, 2'b00, 2, 4, -1);
    check_eq("n5_64", cycles(t_start, t_end), PEN ? 64 : 56);
    send_check("n3_clamp", 8'hff, 3, 2'b00, 2'b00, 2, 4, -1);
    check_eq("n3_56", cycles(t_start, t_end), 56);
    send_check("n15_clamp", 8'h81, 15, 2'b00, 2'b00, 2, 4, -1);
    check_eq("n15_80", cycles(t_start, t_end), 80);

    send_check("stop1p5", 8'h83, 8, 2'b00, 2'b01, 2, 4, -1);
    check_eq("stop1p5_84", cycles(t_start, t_end), 84);
    send_check("stop2", 8'h83, 8, 2'b00, 2'b10, 2, 4, -1);
    check_eq("stop2_88", cycles(t_start, t_end), 88);
    send_check("stop11", 8'h83, 8, 2'b00, 2'b11, 2, 4, -1);
    check_eq("stop11_88", cycles(t_start, t_end), 88);

    send_check("d0r0", 8'h5a, 8, 2'b00, 2'b00, 0, 0, -1);
    check_eq("d0r0_10", cycles(t_start, t_end), 10);
    send_check("r1_1p5", 8'h13, 5, 2'b00, 2'b01, 3, 1, -1);
    check_eq("r1_1p5_21", cycles(t_start, t_end), 21);

    send_check("mid_shoot", 8'h83, 8, 2'b10, 2'b00, 2, 4, 30);
    check_eq("mid_88", cycles(t_start, t_end), PEN ? 88 : 80);

    send_check("edge_shoot", 8'h83, 8, 2'b00, 2'b00, 2, 4, 79);
    @(posedge clk);
    #1;
    check_eq("edge_ignored", tx_if.busytx_o, 0);

    send_check("b2b_a", 8'ha5, 8, 2'b00, 2'b00, 1, 2, -1);
    prev_end = t_end;
    send_check("b2b_b", 8'h3c, 6, 2'b01, 2'b00, 1, 2, -1);
    check_eq("b2b_gap", cycles(prev_end, t_start), 1);

    @(negedge clk);
    nbits = 4'd8;
    ptype = 2'b00;
    stype = 2'b00;
    div   = 16'd2;
    ovs   = 8'd4;
    tx_if.datatx_i = 8'h83;
    tx_if.shoot_i  = 1'b1;
    @(posedge clk);
    #1;
    tx_if.shoot_i = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    check_eq("pre_rst_txd", txd, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_txd", txd, 1);
    check_eq("async_rst_busy", tx_if.busytx_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_check("after_rst", 8'h83, 8, 2'b10, 2'b00, 2, 4, -1);
    check_eq("after_rst_88", cycles(t_start, t_end), PEN ? 88 : 80);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
